// File: rtl/lin_pid_chk.sv
// LIN slave protected-identifier checker.
// Validates the PID after break/sync and sequences the response slots.
module lin_pid_chk #(
  parameter int         LEN_MODE   = 1,
  parameter logic [5:0] RSVD_ID_LO = 6'h3E
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_slv_operation,
  input  logic [9:0] rx_data,
  input  logic       brk_seq_chkd,
  output logic [5:0] pid_id,
  output logic       pid_valid,
  output logic       pid_err,
  output logic [1:0] err_code,
  output logic [3:0] data_len,
  output logic       data_phase,
  output logic [3:0] slot_cnt,
  output logic       abort
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PID  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0] state_q, state_d;
  logic       brk_prev_q, brk_prev_d;
  logic [5:0] pid_id_q, pid_id_d;
  logic       pid_valid_q, pid_valid_d;
  logic       pid_err_q, pid_err_d;
  logic [1:0] err_code_q, err_code_d;
  logic [3:0] data_len_q, data_len_d;
  logic       data_phase_q, data_phase_d;
  logic [3:0] slot_cnt_q, slot_cnt_d;
  logic       abort_q, abort_d;

  logic       brk_rise;
  logic [7:0] pid_byte;
  logic [5:0] id_w;
  logic       p0_w, p1_w;
  logic [1:0] code_w;
  logic [3:0] len_w;

  assign brk_rise = brk_seq_chkd & ~brk_prev_q;
  assign pid_byte = rx_data[8:1];
  assign id_w     = pid_byte[5:0];
  assign p0_w     = id_w[0] ^ id_w[1] ^ id_w[2] ^ id_w[4];
  assign p1_w     = ~(id_w[1] ^ id_w[3] ^ id_w[4] ^ id_w[5]);

  // PID verdict and response length decoded from the current symbol
  always_comb begin
    code_w = 2'b00;
    if (rx_data[0] != 1'b0 || rx_data[9] != 1'b1)
      code_w = 2'b01;
    else if (pid_byte[6] != p0_w || pid_byte[7] != p1_w)
      code_w = 2'b10;
    else if (id_w >= RSVD_ID_LO)
      code_w = 2'b11;

    len_w = 4'd8;
    if (LEN_MODE != 0) begin
      case (id_w[5:4])
        2'b10:   len_w = 4'd4;
        2'b11:   len_w = 4'd8;
        default: len_w = 4'd2;
      endcase
    end
  end

  // Next-state logic: edge detect, PID capture and slot sequencing
  always_comb begin
    state_d      = state_q;
    brk_prev_d   = brk_seq_chkd;
    pid_id_d     = pid_id_q;
    pid_valid_d  = 1'b0;
    pid_err_d    = 1'b0;
    err_code_d   = err_code_q;
    data_len_d   = data_len_q;
    data_phase_d = data_phase_q;
    slot_cnt_d   = slot_cnt_q;
    abort_d      = 1'b0;

    if (!en_slv_operation) begin
      state_d      = S_IDLE;
      data_phase_d = 1'b0;
      slot_cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (brk_rise)
            state_d = S_PID;
        end
        S_PID: begin
          pid_id_d   = id_w;
          err_code_d = code_w;
          data_len_d = len_w;
          slot_cnt_d = 4'd0;
          if (code_w != 2'b00) begin
            pid_err_d    = 1'b1;
            data_phase_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            pid_valid_d  = 1'b1;
            data_phase_d = 1'b1;
            state_d      = S_DATA;
          end
        end
        S_DATA: begin
          if (rx_data == 10'h000 || brk_rise) begin
            abort_d      = 1'b1;
            data_phase_d = 1'b0;
            slot_cnt_d   = 4'd0;
            state_d      = brk_rise ? S_PID : S_IDLE;
          end else if (slot_cnt_q == data_len_q) begin
            data_phase_d = 1'b0;
            slot_cnt_d   = 4'd0;
            state_d      = S_IDLE;
          end else begin
            slot_cnt_d = slot_cnt_q + 4'd1;
          end
        end
        default: begin
          state_d      = S_IDLE;
          data_phase_d = 1'b0;
          slot_cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      brk_prev_q   <= 1'b0;
      pid_id_q     <= 6'd0;
      pid_valid_q  <= 1'b0;
      pid_err_q    <= 1'b0;
      err_code_q   <= 2'b00;
      data_len_q   <= 4'd0;
      data_phase_q <= 1'b0;
      slot_cnt_q   <= 4'd0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      brk_prev_q   <= brk_prev_d;
      pid_id_q     <= pid_id_d;
      pid_valid_q  <= pid_valid_d;
      pid_err_q    <= pid_err_d;
      err_code_q   <= err_code_d;
      data_len_q   <= data_len_d;
      data_phase_q <= data_phase_d;
      slot_cnt_q   <= slot_cnt_d;
      abort_q      <= abort_d;
    end
  end

  assign pid_id     = pid_id_q;
  assign pid_valid  = pid_valid_q;
  assign pid_err    = pid_err_q;
  assign err_code   = err_code_q;
  assign data_len   = data_len_q;
  assign data_phase = data_phase_q;
  assign slot_cnt   = slot_cnt_q;
  assign abort      = abort_q;

endmodule
